fp_addsub_seq: RTL and testbench

- Multicycle, handshaked IEEE-754 single-precision adder/subtractor.
- Acts as the responder for an operand-issuing initiator: the initiator presents `operand_1`/`operand_2` plus an op select and pulses `start`; the block returns `Sum` with a one-cycle `done`.
- Sits beside the combinational adder datapath in the FP unit and is the sequenced, registered version used by the FP scheduler.

---
 rtl/fp_addsub_seq_if.sv | 29 ++
 rtl/fp_addsub_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// Operand/result bundle between the FP scheduler (master) and the sequenced
// adder/subtractor (slave).
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         sub;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         invalid;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, sub, operand_1, operand_2,
    input  busy, done, Sum, invalid, overflow, underflow
  );

  modport slave (
    input  start, sub, operand_1, operand_2,
    output busy, done, Sum, invalid, overflow, underflow
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multicycle IEEE-754 adder/subtractor: IDLE -> ALIGN -> ADD -> NORM -> ROUND,
// round-to-nearest-even, flush-to-zero for denormal inputs and results.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            rst_n,
  fp_addsub_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int SE_W  = EXP_W + 2;

  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(EXT_W);
  localparam logic [SE_W-1:0]  EXP_OVF   = {2'b00, EXP_ONES};
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;

  logic [2:0]   state;
  logic         busy_q, done_q, inv_q, ovf_q, unf_q;
  logic [W-1:0] sum_q;

  logic [W-1:0] op_a, op_b;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb;
  logic [W-2:0]     mag_a, mag_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             swap;
  logic             big_s;
  logic [EXP_W-1:0] big_e, sml_e, diff;
  logic [SIG_W-1:0] big_sig, sml_sig;
  logic [EXT_W-1:0] sml_ext, sml_shr, lost_mask, sml_aligned;

  logic             sp_en_d, sp_inv_d;
  logic [W-1:0]     sp_val_d;

  logic             al_sign, al_eff_sub;
  logic [SE_W-1:0]  al_exp;
  logic [EXT_W-1:0] al_sig_a, al_sig_b;
  logic             sp_en, sp_inv;
  logic [W-1:0]     sp_val;

  logic [EXT_W:0]   add_sum;

  logic [SE_W-1:0]  lz;
  logic [EXT_W-1:0] nm_sig;
  logic [SE_W-1:0]  nm_exp;
  logic             nm_zero;

  logic             rnd_up;
  logic [SIG_W:0]   rounded;
  logic [SE_W-1:0]  exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res_sum;
  logic             res_inv, res_ovf, res_unf;

  function automatic logic [SE_W-1:0] lzc(input logic [EXT_W-1:0] v);
    lzc = SE_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (v[i]) lzc = SE_W'(EXT_W - 1 - i);
    end
  endfunction

  // Unpack and classify; exponent-zero encodings are treated as signed zero.
  assign {sa, ea, fa} = op_a;
  assign {sb, eb, fb} = op_b;

  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == EXP_ONES) && (fa == '0);
  assign ib = (eb == EXP_ONES) && (fb == '0);
  assign na = (ea == EXP_ONES) && (fa != '0);
  assign nb = (eb == EXP_ONES) && (fb != '0);

  assign mag_a = za ? '0 : op_a[W-2:0];
  assign mag_b = zb ? '0 : op_b[W-2:0];
  assign sig_a = za ? '0 : {1'b1, fa};
  assign sig_b = zb ? '0 : {1'b1, fb};

  assign swap    = (mag_b > mag_a);
  assign big_s   = swap ? sb : sa;
  assign big_e   = swap ? eb : ea;
  assign sml_e   = swap ? ea : eb;
  assign big_sig = swap ? sig_b : sig_a;
  assign sml_sig = swap ? sig_a : sig_b;
  assign diff    = big_e - sml_e;

  // Everything shifted past the sticky position collapses into the sticky bit.
  always_comb begin
    sml_ext   = {sml_sig, 3'b000};
    sml_shr   = sml_ext >> diff;
    lost_mask = ~({EXT_W{1'b1}} << diff);
    if (diff >= SHIFT_LIM) begin
      sml_aligned = {{(EXT_W-1){1'b0}}, |sml_ext};
    end else begin
      sml_aligned = sml_shr | {{(EXT_W-1){1'b0}}, |(sml_ext & lost_mask)};
    end
  end

  always_comb begin
    sp_en_d  = 1'b1;
    sp_inv_d = 1'b0;
    sp_val_d = QNAN;
    if (na || nb || (ia && ib && (sa != sb))) begin
      sp_inv_d = 1'b1;
    end else if (ia) begin
      sp_val_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ib) begin
      sp_val_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (za && zb) begin
      sp_val_d = {sa & sb, {(W-1){1'b0}}};
    end else begin
      sp_en_d = 1'b0;
    end
  end

  assign lz = lzc(add_sum[EXT_W-1:0]);

  // Round-to-nearest-even on G/R/S, then saturate or flush on the final exponent.
  always_comb begin
    rnd_up  = nm_sig[2] & ((|nm_sig[1:0]) | nm_sig[3]);
    rounded = {1'b0, nm_sig[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd_up};
    exp_r   = nm_exp + {{(SE_W-1){1'b0}}, rounded[SIG_W]};
    frac_r  = rounded[SIG_W] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    res_sum = {al_sign, exp_r[EXP_W-1:0], frac_r};
    res_inv = 1'b0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (sp_en) begin
      res_sum = sp_val;
      res_inv = sp_inv;
    end else if (nm_zero) begin
      res_sum = '0;
    end else if (exp_r[SE_W-1] || (exp_r == '0)) begin
      res_sum = {al_sign, {(W-1){1'b0}}};
      res_unf = 1'b1;
    end else if (exp_r >= EXP_OVF) begin
      res_sum = {al_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      al_sign    <= 1'b0;
      al_eff_sub <= 1'b0;
      al_exp     <= '0;
      al_sig_a   <= '0;
      al_sig_b   <= '0;
      sp_en      <= 1'b0;
      sp_inv     <= 1'b0;
      sp_val     <= '0;
      add_sum    <= '0;
      nm_sig     <= '0;
      nm_exp     <= '0;
      nm_zero    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_a <= bus.operand_1;
            op_b <= {bus.operand_2[W-1] ^ bus.sub, bus.operand_2[W-2:0]};
          end
        end
        ST_ALIGN: begin
          al_sign    <= big_s;
          al_eff_sub <= sa ^ sb;
          al_exp     <= {2'b00, big_e};
          al_sig_a   <= {big_sig, 3'b000};
          al_sig_b   <= sml_aligned;
          sp_en      <= sp_en_d;
          sp_inv     <= sp_inv_d;
          sp_val     <= sp_val_d;
        end
        ST_ADD: begin
          add_sum <= al_eff_sub ? ({1'b0, al_sig_a} - {1'b0, al_sig_b})
                                : ({1'b0, al_sig_a} + {1'b0, al_sig_b});
        end
        ST_NORM: begin
          nm_zero <= (add_sum == '0);
          if (add_sum[EXT_W]) begin
            nm_sig <= {add_sum[EXT_W:2], add_sum[1] | add_sum[0]};
            nm_exp <= al_exp + SE_W'(1);
          end else begin
            nm_sig <= add_sum[EXT_W-1:0] << lz;
            nm_exp <= al_exp - lz;
          end
        end
        default: ;
      endcase
    end
  end

  // Flags clear when a request is accepted; Sum holds its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      inv_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_ALIGN;
            busy_q <= 1'b1;
            inv_q  <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
          end
        end
        ST_ALIGN: state <= ST_ADD;
        ST_ADD:   state <= ST_NORM;
        ST_NORM:  state <= ST_ROUND;
        ST_ROUND: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          sum_q  <= res_sum;
          inv_q  <= res_inv;
          ovf_q  <= res_ovf;
          unf_q  <= res_unf;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Sum       = sum_q;
  assign bus.invalid   = inv_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: exact-integer reference model, scoreboard
// checked on every done pulse, plus latency, reset and handshake checks.
module tb_fp_addsub_seq;
  logic clk;
  logic rst_n;

  fp_addsub_seq_if bus ();

  fp_addsub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks    = 0;
  int          errors    = 0;
  int          done_seen = 0;
  logic [34:0] exp_q[$];
  logic [31:0] last_sum  = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place both operands on one exact integer grid (units of 2^-149),
  // add exactly, then round the exact result to 24 bits. Returns {inv,ovf,unf,sum}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic         sx, sy, sign, up;
    logic [7:0]   ex, ey;
    logic [22:0]  fx, fy;
    logic [299:0] vx, vy, m, q, rem, half;
    int           p, sh, e;
    sx = x[31]; ex = x[30:23]; fx = x[22:0];
    sy = y[31] ^ s; ey = y[30:23]; fy = y[22:0];
    sign = 1'b0; up = 1'b0; rem = '0; half = '0;
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) return {3'b100, 32'h7FC00000};
    if (ex == 8'hFF && ey == 8'hFF)
      return (sx == sy) ? {3'b000, sx, 31'h7F800000} : {3'b100, 32'h7FC00000};
    if (ex == 8'hFF) return {3'b000, sx, 31'h7F800000};
    if (ey == 8'hFF) return {3'b000, sy, 31'h7F800000};
    vx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (int'(ex) - 1));
    vy = (ey == 0) ? '0 : (300'({1'b1, fy}) << (int'(ey) - 1));
    if (sx == sy) begin
      m = vx + vy; sign = sx;
    end else if (vx >= vy) begin
      m = vx - vy; sign = sx;
    end else begin
      m = vy - vx; sign = sy;
    end
    if (m == 0) return {3'b000, (vx == 0 && vy == 0) ? (sx & sy) : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p < 23) return {3'b001, sign, 31'h0};
    sh = p - 23;
    q  = m >> sh;
    if (sh > 0) begin
      rem  = m & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && q[0]);
    end
    q = q + 300'(up);
    e = p - 22;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {3'b010, sign, 31'h7F800000};
    if (e < 1) return {3'b001, sign, 31'h0};
    return {3'b000, sign, 8'(e), q[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [34:0] want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        done_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: got Sum %h with no request outstanding", bus.Sum);
        end else begin
          want = exp_q.pop_front();
          if ({bus.invalid, bus.overflow, bus.underflow, bus.Sum} !== want) begin
            errors++;
            $display("[TB] FAIL result: got inv/ovf/unf %b%b%b Sum %h expected %b Sum %h",
                     bus.invalid, bus.overflow, bus.underflow, bus.Sum, want[34:32], want[31:0]);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [31:0] lit_sum, input logic [2:0] lit_flags);
    logic [34:0] m;
    int lat, busy_cycles;
    m = model(a, b, s);
    checkOutput("model_pin", 64'(m), 64'({lit_flags, lit_sum}));
    exp_q.push_back(m);
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.sub       = s;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.operand_1 = $urandom;
    bus.operand_2 = $urandom;
    bus.sub       = 1'($urandom);
    checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
    checkOutput("flags_cleared", 64'({bus.invalid, bus.overflow, bus.underflow}), 64'd0);
    checkOutput("sum_held", 64'(bus.Sum), 64'(last_sum));
    busy_cycles = 1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    checkOutput("latency", 64'(lat), 64'd4);
    checkOutput("busy_cycles", 64'(busy_cycles), 64'd4);
    last_sum = m[31:0];
  endtask

  initial begin
    logic [34:0] m;
    int seen0, lat;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.operand_1 = '0; bus.operand_2 = '0;
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_outputs",
                64'({bus.busy, bus.done, bus.invalid, bus.overflow, bus.underflow, bus.Sum}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Consecutive calls issue each request in the previous done cycle.
    applyStimulus(32'h3FC00000, 32'h415B0000, 1'b0, 32'h41730000, 3'b000);
    applyStimulus(32'h3F180000, 32'h415B0000, 1'b0, 32'h41648000, 3'b000);
    applyStimulus(32'h415B0000, 32'h3FC00000, 1'b1, 32'h41430000, 3'b000);
    applyStimulus(32'h415B0000, 32'h415B0000, 1'b1, 32'h00000000, 3'b000);
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    applyStimulus(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
    applyStimulus(32'hC0200000, 32'h3F800000, 1'b0, 32'hBFC00000, 3'b000);
    applyStimulus(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000);
    applyStimulus(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000);
    applyStimulus(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    applyStimulus(32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    applyStimulus(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    applyStimulus(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    applyStimulus(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    applyStimulus(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
    applyStimulus(32'h80800001, 32'h00800000, 1'b0, 32'h80000000, 3'b001);
    applyStimulus(32'h3F800000, 32'h33800001, 1'b1, 32'h3F7FFFFF, 3'b000);
    applyStimulus(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b010);
    applyStimulus(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000);
    applyStimulus(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);

    // A second start while busy must be ignored.
    @(posedge clk); #1;
    m = model(32'h40000000, 32'h40400000, 1'b0);
    checkOutput("model_pin_ignore", 64'(m), 64'({3'b000, 32'h40A00000}));
    exp_q.push_back(m);
    seen0 = done_seen;
    bus.operand_1 = 32'h40000000; bus.operand_2 = 32'h40400000; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.operand_1 = 32'h3F800000; bus.operand_2 = 32'h3F800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 2;
    while (bus.done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("ignored_start_latency", 64'(lat), 64'd4);
    repeat (8) @(posedge clk); #1;
    checkOutput("ignored_start_one_done", 64'(done_seen - seen0), 64'd1);
    checkOutput("ignored_start_queue", 64'(exp_q.size()), 64'd0);
    last_sum = m[31:0];

    // Reset two cycles into an operation aborts it without a done pulse.
    seen0 = done_seen;
    bus.operand_1 = 32'h3FC00000; bus.operand_2 = 32'h415B0000; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("busy_before_reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_op",
                64'({bus.busy, bus.done, bus.invalid, bus.overflow, bus.underflow, bus.Sum}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    checkOutput("reset_no_done", 64'(done_seen - seen0), 64'd0);
    checkOutput("reset_idle_busy", 64'(bus.busy), 64'd0);
    last_sum = 32'h0;

    applyStimulus(32'h3FC00000, 32'h415B0000, 1'b0, 32'h41730000, 3'b000);
    repeat (3) @(posedge clk); #1;
    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
